// File: rtl/video_ula.sv
// Video ULA: CRTC clock enable, screen byte serialiser, 16-entry palette, flash,
// display-enable blanking, segmented cursor and teletext pass-through.
module video_ula (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PROC_en,
  input  logic       nCS_VULA,
  input  logic       RnW,
  input  logic       A0,
  input  logic [7:0] pDATABUS,
  input  logic [7:0] vDATA,
  input  logic       DISEN,
  input  logic       CURSOR,
  input  logic [2:0] TTX_RGB,
  output logic       CRTC_en,
  output logic       TTX_MODE,
  output logic [2:0] RGB
);

  logic [3:0] clkCount_q;
  logic [7:0] ctrl_q;
  logic [3:0] palette_q [16];
  logic [7:0] shiftReg_q, shiftReg_d;
  logic       disen_q;
  logic [2:0] cseg_q, cseg_d;
  logic [2:0] rgb_q, rgb_d;

  logic       writeEn;
  logic       shiftEn;
  logic       cursorVis;
  logic [3:0] logical;
  logic [3:0] entry;
  logic [2:0] physical;

  assign writeEn  = ~nCS_VULA & ~RnW & PROC_en;
  assign TTX_MODE = ctrl_q[1];
  assign RGB      = rgb_q;

  always_comb begin
    CRTC_en = ctrl_q[4] ? (clkCount_q[2:0] == 3'd7) : (clkCount_q == 4'd15);
  end

  always_comb begin
    shiftEn = 1'b0;
    case (ctrl_q[3:2])
      2'b11:   shiftEn = 1'b1;
      2'b10:   shiftEn = clkCount_q[0];
      2'b01:   shiftEn = (clkCount_q[1:0] == 2'd3);
      default: shiftEn = (clkCount_q[2:0] == 3'd7);
    endcase
  end

  // A load wins over a shift; shifting fills with ones so spare pixels read colour 15.
  always_comb begin
    shiftReg_d = shiftReg_q;
    cseg_d     = cseg_q;
    if (CRTC_en) begin
      shiftReg_d = DISEN ? vDATA : 8'h00;
      if (CURSOR) begin
        cseg_d = 3'd1;
      end else if (cseg_q != 3'd0) begin
        cseg_d = (cseg_q == 3'd4) ? 3'd0 : cseg_q + 3'd1;
      end
    end else if (shiftEn) begin
      shiftReg_d = {shiftReg_q[6:0], 1'b1};
    end
  end

  always_comb begin
    cursorVis = 1'b0;
    case (cseg_q)
      3'd1:       cursorVis = ctrl_q[7];
      3'd2:       cursorVis = ctrl_q[6];
      3'd3, 3'd4: cursorVis = ctrl_q[5];
      default:    cursorVis = 1'b0;
    endcase
  end

  always_comb begin
    logical  = {shiftReg_q[7], shiftReg_q[5], shiftReg_q[3], shiftReg_q[1]};
    entry    = palette_q[logical];
    physical = ~entry[2:0] ^ {3{entry[3] & ctrl_q[0]}};
    rgb_d    = (ctrl_q[1] ? TTX_RGB : (disen_q ? physical : 3'b000)) ^ {3{cursorVis}};
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      clkCount_q <= 4'd0;
      ctrl_q     <= 8'h00;
      shiftReg_q <= 8'h00;
      disen_q    <= 1'b0;
      cseg_q     <= 3'd0;
      rgb_q      <= 3'b000;
    end else begin
      clkCount_q <= clkCount_q + 4'd1;
      shiftReg_q <= shiftReg_d;
      cseg_q     <= cseg_d;
      rgb_q      <= rgb_d;
      if (CRTC_en) begin
        disen_q <= DISEN;
      end
      if (writeEn && !A0) begin
        ctrl_q <= pDATABUS;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 0; i < 16; i++) begin
        palette_q[i] <= 4'h0;
      end
    end else if (writeEn && A0) begin
      palette_q[pDATABUS[7:4]] <= pDATABUS[3:0];
    end
  end

endmodule

// File: tb/tb_video_ula.sv
// Bench for video_ula: table of single-character vectors, directed cursor/teletext/reset
// sequences, and a randomized run checked every cycle against a reference model.
module tb_video_ula;

  logic       CLK;
  logic       nRESET;
  logic       PROC_en;
  logic       nCS_VULA;
  logic       RnW;
  logic       A0;
  logic [7:0] pDATABUS;
  logic [7:0] vDATA;
  logic       DISEN;
  logic       CURSOR;
  logic [2:0] TTX_RGB;
  logic       CRTC_en;
  logic       TTX_MODE;
  logic [2:0] RGB;

  int nCompared;
  int nMismatched;

  video_ula dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .PROC_en  (PROC_en),
    .nCS_VULA (nCS_VULA),
    .RnW      (RnW),
    .A0       (A0),
    .pDATABUS (pDATABUS),
    .vDATA    (vDATA),
    .DISEN    (DISEN),
    .CURSOR   (CURSOR),
    .TTX_RGB  (TTX_RGB),
    .CRTC_en  (CRTC_en),
    .TTX_MODE (TTX_MODE),
    .RGB      (RGB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    logic [7:0] pal0;
    logic [7:0] pal1;
    logic [7:0] vData;
    logic       disen;
    logic [2:0] ttx;
    logic [2:0] expFirst;
    logic [2:0] expLate;
  } vec_t;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic cpuWrite(input logic a, input logic [7:0] d);
    PROC_en  = 1'b1;
    nCS_VULA = 1'b0;
    RnW      = 1'b0;
    A0       = a;
    pDATABUS = d;
    tick();
    PROC_en  = 1'b0;
    nCS_VULA = 1'b1;
    RnW      = 1'b1;
  endtask

  task automatic doReset();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
  endtask

  // Returns at the observation point just before the load edge.
  task automatic waitLoad(input string name);
    int n;
    n = 0;
    while (CRTC_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (CRTC_en !== 1'b1) checkOutput({name, "_timeout"}, {7'b0, CRTC_en}, 8'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    doReset();
    vDATA   = v.vData;
    DISEN   = v.disen;
    TTX_RGB = v.ttx;
    CURSOR  = 1'b0;
    cpuWrite(1'b0, v.ctrl);
    cpuWrite(1'b1, v.pal0);
    cpuWrite(1'b1, v.pal1);
    waitLoad(v.name);
    tick();
    tick();
    checkOutput({v.name, "_first"}, {5'b0, RGB}, {5'b0, v.expFirst});
    ticks(4);
    checkOutput({v.name, "_late"}, {5'b0, RGB}, {5'b0, v.expLate});
  endtask

  // Reference model: tracks the loaded byte and shifts since load, and the age of the cursor in characters.
  int         mClk;
  logic [7:0] mCtrl;
  logic [3:0] mPal [16];
  int         mByte;
  int         mShifts;
  logic       mDisen;
  int         mAge;
  logic [2:0] mRgb;
  bit         mValid;

  initial mValid = 1'b0;

  always @(negedge CLK) begin : refModel
    int         period;
    int         pix;
    int         lc;
    logic [3:0] e;
    logic [2:0] p;
    logic [2:0] base;
    logic       cv;
    logic       en;
    logic       sh;
    en = mCtrl[4] ? (mClk % 8 == 7) : (mClk == 15);
    if (mValid) begin
      checkOutput("monRGB", {5'b0, RGB}, {5'b0, mRgb});
      checkOutput("monCRTC_en", {7'b0, CRTC_en}, {7'b0, en});
      checkOutput("monTTX_MODE", {7'b0, TTX_MODE}, {7'b0, mCtrl[1]});
    end
    if (nRESET !== 1'b1) begin
      mClk    = 0;
      mCtrl   = 8'h00;
      for (int i = 0; i < 16; i++) mPal[i] = 4'h0;
      mByte   = 0;
      mShifts = 0;
      mDisen  = 1'b0;
      mAge    = 0;
      mRgb    = 3'b000;
      mValid  = 1'b1;
    end else if (mValid) begin
      period = 8 >> mCtrl[3:2];
      sh     = (mClk % period) == (period - 1);
      pix    = ((mByte << mShifts) | ((1 << mShifts) - 1)) & 255;
      lc     = ((pix >> 7) & 1) * 8 + ((pix >> 5) & 1) * 4 + ((pix >> 3) & 1) * 2 + ((pix >> 1) & 1);
      e      = mPal[lc];
      p      = (~e[2:0]) ^ ((e[3] && mCtrl[0]) ? 3'b111 : 3'b000);
      if (mAge == 1)                   cv = mCtrl[7];
      else if (mAge == 2)              cv = mCtrl[6];
      else if (mAge == 3 || mAge == 4) cv = mCtrl[5];
      else                             cv = 1'b0;
      base = mCtrl[1] ? TTX_RGB : (mDisen ? p : 3'b000);
      mRgb = base ^ (cv ? 3'b111 : 3'b000);
      if (!nCS_VULA && !RnW && PROC_en) begin
        if (A0) mPal[pDATABUS[7:4]] = pDATABUS[3:0];
        else    mCtrl = pDATABUS;
      end
      if (en) begin
        mByte   = DISEN ? int'(vDATA) : 0;
        mShifts = 0;
        mDisen  = DISEN;
        if (CURSOR)         mAge = 1;
        else if (mAge >= 4) mAge = 0;
        else if (mAge > 0)  mAge = mAge + 1;
      end else if (sh && mShifts < 8) begin
        mShifts = mShifts + 1;
      end
      mClk = (mClk + 1) % 16;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainTest
    vec_t vecs [11];
    int   n;
    nCompared   = 0;
    nMismatched = 0;
    nRESET   = 1'b0;
    PROC_en  = 1'b0;
    nCS_VULA = 1'b1;
    RnW      = 1'b1;
    A0       = 1'b0;
    pDATABUS = 8'h00;
    vDATA    = 8'h00;
    DISEN    = 1'b0;
    CURSOR   = 1'b0;
    TTX_RGB  = 3'b000;

    vecs[0]  = '{"pal0_8mhz",    8'h98, 8'h00, 8'h00, 8'hAA, 1'b1, 3'd2, 3'd7, 3'd7};
    vecs[1]  = '{"ones_fill",    8'h18, 8'h0F, 8'hF0, 8'hFF, 1'b1, 3'd2, 3'd7, 3'd7};
    vecs[2]  = '{"flash_on",     8'h19, 8'h0F, 8'hF0, 8'h00, 1'b1, 3'd2, 3'd7, 3'd7};
    vecs[3]  = '{"flash_off",    8'h18, 8'h0F, 8'hF0, 8'h00, 1'b1, 3'd2, 3'd0, 3'd7};
    vecs[4]  = '{"disen_blank",  8'h18, 8'h05, 8'h00, 8'hFF, 1'b0, 3'd2, 3'd0, 3'd0};
    vecs[5]  = '{"two_colours",  8'h18, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd2, 3'd5, 3'd1};
    vecs[6]  = '{"flash_mixed",  8'h19, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd2, 3'd2, 3'd1};
    vecs[7]  = '{"rate16",       8'h1C, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd2, 3'd5, 3'd7};
    vecs[8]  = '{"rate2",        8'h10, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd2, 3'd5, 3'd5};
    vecs[9]  = '{"ttx_vec",      8'h12, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd5, 3'd5, 3'd5};
    vecs[10] = '{"crtc1mhz",     8'h08, 8'h6A, 8'hD6, 8'h28, 1'b1, 3'd2, 3'd5, 3'd1};

    // Power-up reset state and first CRTC enable on the 16th clock.
    tick();
    tick();
    checkOutput("rst_RGB", {5'b0, RGB}, 8'd0);
    checkOutput("rst_TTX_MODE", {7'b0, TTX_MODE}, 8'd0);
    checkOutput("rst_CRTC_en", {7'b0, CRTC_en}, 8'd0);
    nRESET = 1'b1;
    n = 0;
    while (CRTC_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("powerup_crtc_gap", 8'(n), 8'd15);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Cursor with all three segment enables: four inverted character periods.
    doReset();
    vDATA  = 8'h00;
    DISEN  = 1'b1;
    CURSOR = 1'b0;
    cpuWrite(1'b0, 8'hFC);
    waitLoad("cursorAll");
    CURSOR = 1'b1;
    tick();
    CURSOR = 1'b0;
    tick();
    checkOutput("cursorAll_t1", {5'b0, RGB}, 8'd0);
    ticks(7);
    checkOutput("cursorAll_t8", {5'b0, RGB}, 8'd0);
    ticks(24);
    checkOutput("cursorAll_t32", {5'b0, RGB}, 8'd0);
    tick();
    checkOutput("cursorAll_t33", {5'b0, RGB}, 8'd7);

    // Only the top segment enabled.
    cpuWrite(1'b0, 8'h9C);
    waitLoad("cursorTop");
    CURSOR = 1'b1;
    tick();
    CURSOR = 1'b0;
    tick();
    checkOutput("cursorTop_t1", {5'b0, RGB}, 8'd0);
    ticks(7);
    checkOutput("cursorTop_t8", {5'b0, RGB}, 8'd0);
    tick();
    checkOutput("cursorTop_t9", {5'b0, RGB}, 8'd7);

    // Teletext pass-through one clock after the control write.
    doReset();
    TTX_RGB = 3'b101;
    cpuWrite(1'b0, 8'h02);
    checkOutput("ttx_mode", {7'b0, TTX_MODE}, 8'd1);
    checkOutput("ttx_rgb_before", {5'b0, RGB}, 8'd0);
    tick();
    checkOutput("ttx_rgb_after", {5'b0, RGB}, 8'd5);

    // Reset mid-character clears everything and restarts CRTC timing.
    doReset();
    TTX_RGB = 3'b110;
    vDATA   = 8'hAA;
    cpuWrite(1'b0, 8'h9A);
    ticks(11);
    checkOutput("midrst_pre_RGB", {5'b0, RGB}, 8'd6);
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    checkOutput("midrst_RGB", {5'b0, RGB}, 8'd0);
    checkOutput("midrst_TTX_MODE", {7'b0, TTX_MODE}, 8'd0);
    n = 0;
    while (CRTC_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("midrst_crtc_gap", 8'(n), 8'd15);

    // Randomized traffic; the reference model checks every cycle.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      nRESET   = ($urandom_range(0, 499) != 0);
      PROC_en  = ($urandom_range(0, 7) == 0);
      nCS_VULA = ($urandom_range(0, 5) == 0);
      RnW      = ($urandom_range(0, 4) == 0);
      A0       = 1'($urandom_range(0, 1));
      pDATABUS = 8'($urandom);
      vDATA    = 8'($urandom);
      DISEN    = ($urandom_range(0, 3) != 0);
      CURSOR   = ($urandom_range(0, 19) == 0);
      TTX_RGB  = 3'($urandom);
      tick();
    end
    nRESET  = 1'b1;
    PROC_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
